mdu_iter: RTL

- Parametrised iterative multiply/divide unit that produces HI/LO results for the EX stage.
- Replaces single-cycle combinational multiply and the fixed two-pass MADD/MSUB counter scheme with one shared sequencer.
- EX drives start/annul and stalls the pipeline while busy_o=1; the result is written to HI/LO via the existing whilo path.
- Handles signed/unsigned multiply, divide and, optionally, multiply-accumulate/subtract.

---
 rtl/mdu_iter.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit producing {HI,LO} for the EX stage via one shared sequencer.
// Define MDU_ACCUM_EN to enable MADD/MADDU/MSUB/MSUBU accumulation against the latched hilo_i.
module mdu_iter #(
    parameter int DATA_W   = 32,
    parameter int MUL_STEP = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic [2*DATA_W-1:0]   hilo_i,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  div_zero_o
);

    localparam int RES_W     = 2 * DATA_W;
    localparam int MUL_ITERS = DATA_W / MUL_STEP;
    localparam int CNT_W     = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [2:0]         op_eff_s;
    logic               is_signed_s;
    logic               is_div_s;
    logic               sign1_s;
    logic               sign2_s;
    logic               div_zero_s;
    logic               accept_s;
    logic [DATA_W-1:0]  mag1_s;
    logic [DATA_W-1:0]  mag2_s;
    logic [RES_W-1:0]   prod_s;
    logic [DATA_W-1:0]  quo_s;
    logic [DATA_W-1:0]  rem_s;
    logic [RES_W-1:0]   fixed_s;

    logic [RES_W-1:0]   acc_r;
    logic [RES_W-1:0]   mcand_r;
    logic [DATA_W-1:0]  opb_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               is_div_r;
    logic               neg_r;
    logic               rem_neg_r;
    logic [RES_W-1:0]   result_r;
    logic               div_zero_r;
    logic               valid_r;
    logic               ready_r;
    logic               busy_r;
`ifdef MDU_ACCUM_EN
    logic               acc_en_r;
    logic               sub_r;
    logic [RES_W-1:0]   hilo_r;
`else
    logic               unused_hilo_s;
    assign unused_hilo_s = ^hilo_i;
`endif

    // Sum of the multiplicand shifted by each set bit of one MUL_STEP-wide multiplier slice.
    function automatic logic [RES_W-1:0] partial_prod(input logic [RES_W-1:0] mcand,
                                                      input logic [MUL_STEP-1:0] bits);
        logic [RES_W-1:0] sum;
        sum = {RES_W{1'b0}};
        for (int i = 0; i < MUL_STEP; i++) begin
            if (bits[i]) sum = sum + (mcand << i);
            else         sum = sum;
        end
        return sum;
    endfunction

    // One restoring step on {remainder, dividend/quotient}: shift in the next dividend bit and subtract if it fits.
    function automatic logic [RES_W-1:0] div_step(input logic [RES_W-1:0] rq,
                                                  input logic [DATA_W-1:0] dvsr);
        logic [DATA_W:0] trial;
        logic [DATA_W:0] diff;
        trial = {rq[RES_W-1:DATA_W], rq[DATA_W-1]};
        diff  = trial - {1'b0, dvsr};
        if (trial >= {1'b0, dvsr}) return {diff[DATA_W-1:0], rq[DATA_W-2:0], 1'b1};
        else                       return {trial[DATA_W-1:0], rq[DATA_W-2:0], 1'b0};
    endfunction

    // Operation decode and operand magnitudes for the accept edge.
    always_comb begin
`ifdef MDU_ACCUM_EN
        op_eff_s = op_i;
`else
        if (op_i[2]) op_eff_s = {2'b00, op_i[0]};
        else         op_eff_s = op_i;
`endif
        is_signed_s = ~op_eff_s[0];
        is_div_s    = (op_eff_s[2:1] == 2'b01);
        sign1_s     = is_signed_s & opdata1_i[DATA_W-1];
        sign2_s     = is_signed_s & opdata2_i[DATA_W-1];
        if (sign1_s) mag1_s = -opdata1_i;
        else         mag1_s = opdata1_i;
        if (sign2_s) mag2_s = -opdata2_i;
        else         mag2_s = opdata2_i;
        div_zero_s  = is_div_s & (opdata2_i == {DATA_W{1'b0}});
        accept_s    = (state_r == ST_IDLE) & start_i & ~annul_i;
    end

    // Sign correction and optional accumulate applied in FIX.
    always_comb begin
        if (neg_r) begin
            prod_s = -acc_r;
            quo_s  = -acc_r[DATA_W-1:0];
        end else begin
            prod_s = acc_r;
            quo_s  = acc_r[DATA_W-1:0];
        end
        if (rem_neg_r) rem_s = -acc_r[RES_W-1:DATA_W];
        else           rem_s = acc_r[RES_W-1:DATA_W];
        if (is_div_r)               fixed_s = {rem_s, quo_s};
`ifdef MDU_ACCUM_EN
        else if (acc_en_r & sub_r)  fixed_s = hilo_r - prod_s;
        else if (acc_en_r)          fixed_s = hilo_r + prod_s;
`endif
        else                        fixed_s = prod_s;
    end

    // Next-state logic; annul always returns to IDLE.
    always_comb begin
        state_next_s = state_r;
        if (annul_i) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!accept_s)            state_next_s = ST_IDLE;
                    else if (div_zero_s)      state_next_s = ST_DONE;
                    else if (is_div_s)        state_next_s = ST_DIV;
                    else if (MUL_ITERS > 1)   state_next_s = ST_MUL;
                    else                      state_next_s = ST_FIX;
                end
                ST_MUL, ST_DIV: begin
                    if (cnt_r == CNT_W'(1)) state_next_s = ST_FIX;
                    else                    state_next_s = state_r;
                end
                ST_FIX:  state_next_s = ST_DONE;
                ST_DONE: state_next_s = ST_IDLE;
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_r <= ST_IDLE;
        else      state_r <= state_next_s;
    end

    // Datapath: the accept edge already retires the first iteration, so the loop states run one cycle short.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_r      <= {RES_W{1'b0}};
            mcand_r    <= {RES_W{1'b0}};
            opb_r      <= {DATA_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            is_div_r   <= 1'b0;
            neg_r      <= 1'b0;
            rem_neg_r  <= 1'b0;
            result_r   <= {RES_W{1'b0}};
            div_zero_r <= 1'b0;
`ifdef MDU_ACCUM_EN
            acc_en_r   <= 1'b0;
            sub_r      <= 1'b0;
            hilo_r     <= {RES_W{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        is_div_r   <= is_div_s;
                        neg_r      <= sign1_s ^ sign2_s;
                        rem_neg_r  <= sign1_s;
                        div_zero_r <= div_zero_s;
`ifdef MDU_ACCUM_EN
                        acc_en_r   <= op_eff_s[2];
                        sub_r      <= op_eff_s[1];
                        hilo_r     <= hilo_i;
`endif
                        if (div_zero_s) begin
                            result_r <= {opdata1_i, {DATA_W{1'b1}}};
                        end else if (is_div_s) begin
                            acc_r <= div_step({{DATA_W{1'b0}}, mag1_s}, mag2_s);
                            opb_r <= mag2_s;
                            cnt_r <= CNT_W'(DATA_W - 1);
                        end else begin
                            acc_r   <= partial_prod(RES_W'(mag1_s), mag2_s[MUL_STEP-1:0]);
                            mcand_r <= RES_W'(mag1_s) << MUL_STEP;
                            opb_r   <= mag2_s >> MUL_STEP;
                            cnt_r   <= CNT_W'(MUL_ITERS - 1);
                        end
                    end
                end
                ST_MUL: begin
                    acc_r   <= acc_r + partial_prod(mcand_r, opb_r[MUL_STEP-1:0]);
                    mcand_r <= mcand_r << MUL_STEP;
                    opb_r   <= opb_r >> MUL_STEP;
                    cnt_r   <= cnt_r - CNT_W'(1);
                end
                ST_DIV: begin
                    acc_r <= div_step(acc_r, opb_r);
                    cnt_r <= cnt_r - CNT_W'(1);
                end
                ST_FIX: begin
                    if (!annul_i) result_r <= fixed_s;
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    // Registered handshake outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            ready_r <= (state_next_s == ST_IDLE);
            busy_r  <= (state_next_s == ST_MUL) || (state_next_s == ST_DIV) ||
                       (state_next_s == ST_FIX);
            valid_r <= (state_next_s == ST_DONE);
        end
    end

    assign ready_o    = ready_r;
    assign busy_o     = busy_r;
    assign valid_o    = valid_r;
    assign result_o   = result_r;
    assign div_zero_o = div_zero_r;

endmodule
